// File: rtl/i2s_in.sv
// I2S slave receiver: recovers WIDTH-bit stereo samples from an external {data, lr, ck} bus.
// Optional feature macro: I2S_IN_ERR_EN adds the err output and lets framing errors clear locked.
module i2s_in #(
    parameter int WIDTH = 16,
    parameter int SYNC  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       i2s,
    output logic [WIDTH-1:0] l,
    output logic [WIDTH-1:0] r,
    output logic             strobe,
`ifdef I2S_IN_ERR_EN
    output logic             err,
`endif
    output logic             locked
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_DELAY = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SYNC-1:0]   r_ck_sync;
    logic [SYNC-1:0]   r_lr_sync;
    logic [SYNC-1:0]   r_d_sync;
    logic              r_ck_prev;
    logic              r_lr_rise;
    logic [WIDTH-1:0]  r_shift;
    logic [CW-1:0]     r_cnt;
    logic              r_chan;
    logic [WIDTH-1:0]  r_hold_l;
    logic [WIDTH-1:0]  r_hold_r;
    logic              r_have_l;
    logic              r_pair;

    logic              w_ck;
    logic              w_lr;
    logic              w_d;
    logic              w_rise;
    logic              w_tr;
    logic              w_clr;
    logic              w_take;
    logic              w_fin;
    logic [CW-1:0]     w_cnt_nxt;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic [WIDTH-1:0]  w_word;

    assign w_ck        = r_ck_sync[SYNC-1];
    assign w_lr        = r_lr_sync[SYNC-1];
    assign w_d         = r_d_sync[SYNC-1];
    assign w_rise      = w_ck & ~r_ck_prev;
    // An lr transition only counts when seen at a ck rise, compared to lr at the previous rise.
    assign w_tr        = w_rise & (w_lr != r_lr_rise);
    assign w_cnt_nxt   = r_cnt + CNT_ONE;
    assign w_shift_nxt = {r_shift[WIDTH-2:0], w_d};
    assign w_word      = w_shift_nxt << (CNT_FULL - w_cnt_nxt);

    // Synchronise the I2S lines and keep the edge-detect history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ck_sync <= {SYNC{1'b0}};
            r_lr_sync <= {SYNC{1'b0}};
            r_d_sync  <= {SYNC{1'b0}};
            r_ck_prev <= 1'b0;
            r_lr_rise <= 1'b0;
        end else begin
            r_ck_sync <= {r_ck_sync[SYNC-2:0], i2s[0]};
            r_lr_sync <= {r_lr_sync[SYNC-2:0], i2s[1]};
            r_d_sync  <= {r_d_sync[SYNC-2:0], i2s[2]};
            r_ck_prev <= w_ck;
            if (w_rise) begin
                r_lr_rise <= w_lr;
            end else begin
                r_lr_rise <= r_lr_rise;
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DELAY lasts one system clock, so the next ck rise carries the MSB.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT: begin
                if (w_tr) w_state_nxt = S_DELAY;
                else      w_state_nxt = S_HUNT;
            end
            S_DELAY: w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_tr)                                    w_state_nxt = S_DELAY;
                else if (w_rise && (w_cnt_nxt == CNT_FULL))  w_state_nxt = S_WAIT;
                else                                         w_state_nxt = S_SHIFT;
            end
            S_WAIT: begin
                if (w_tr) w_state_nxt = S_DELAY;
                else      w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // Datapath controls decoded from the state.
    always_comb begin
        w_clr  = 1'b0;
        w_take = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_DELAY: w_clr = 1'b1;
            S_SHIFT: begin
                w_take = w_rise;
                w_fin  = w_rise & (w_tr | (w_cnt_nxt == CNT_FULL));
            end
            default: begin
                w_clr  = 1'b0;
                w_take = 1'b0;
                w_fin  = 1'b0;
            end
        endcase
    end

    // Serial shifter and bit counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_chan  <= 1'b0;
        end else if (w_clr) begin
            r_shift <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_chan  <= r_lr_rise;
        end else if (w_take) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Channel holding registers; a right word after a held left word forms a stereo pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_l <= {WIDTH{1'b0}};
            r_hold_r <= {WIDTH{1'b0}};
            r_have_l <= 1'b0;
            r_pair   <= 1'b0;
        end else if (w_fin && !r_chan) begin
            r_hold_l <= w_word;
            r_have_l <= 1'b1;
            r_pair   <= 1'b0;
        end else if (w_fin) begin
            r_hold_r <= w_word;
            r_have_l <= 1'b0;
            r_pair   <= r_have_l;
        end else begin
            r_pair   <= 1'b0;
        end
    end

`ifdef I2S_IN_ERR_EN
    localparam logic [CW-1:0] GAP_MAX = CW'(WIDTH + 1);

    logic          r_err_ev;
    logic          r_l_bad;
    logic          r_good;
    logic [CW-1:0] r_gap;
    logic          r_gap_vld;
    logic [CW-1:0] w_gap_nxt;
    logic          w_slot_end;
    logic          w_err_ev;

    assign w_gap_nxt  = r_gap + CNT_ONE;
    assign w_slot_end = w_tr & ((r_state == S_SHIFT) | (r_state == S_WAIT));
    assign w_err_ev   = (w_fin & w_tr & (w_cnt_nxt < CNT_FULL))
                      | (w_slot_end & r_gap_vld & (w_gap_nxt < GAP_MAX));

    // Slot-length checking; the gap counts ck rises from one lr transition to the next inclusive.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_ev  <= 1'b0;
            r_l_bad   <= 1'b0;
            r_good    <= 1'b0;
            r_gap     <= {CW{1'b0}};
            r_gap_vld <= 1'b0;
        end else begin
            r_err_ev <= w_err_ev;
            if (w_tr) begin
                r_gap     <= CNT_ONE;
                r_gap_vld <= 1'b1;
            end else if (w_rise && (r_gap != GAP_MAX)) begin
                r_gap     <= w_gap_nxt;
            end
            if (w_fin && !r_chan) begin
                r_l_bad <= w_err_ev;
            end else if (w_fin) begin
                r_good  <= ~r_l_bad & ~w_err_ev;
            end
        end
    end

    // Registered outputs; an error drops lock until a clean pair arrives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l      <= {WIDTH{1'b0}};
            r      <= {WIDTH{1'b0}};
            strobe <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            strobe <= r_pair;
            err    <= r_err_ev;
            if (r_pair) begin
                l <= r_hold_l;
                r <= r_hold_r;
            end
            if (r_err_ev) begin
                locked <= 1'b0;
            end else if (r_pair && r_good) begin
                locked <= 1'b1;
            end
        end
    end
`else
    // Registered outputs; lock is sticky until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l      <= {WIDTH{1'b0}};
            r      <= {WIDTH{1'b0}};
            strobe <= 1'b0;
            locked <= 1'b0;
        end else begin
            strobe <= r_pair;
            if (r_pair) begin
                l      <= r_hold_l;
                r      <= r_hold_r;
                locked <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_in.sv
// Scoreboard bench for i2s_in: a standard I2S transmitter model drives directed frames,
// a monitor compares every strobe against the queued expected pair.
module tb_i2s_in;

    localparam int W = 16;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    i2s     = 3'b000;
    logic [W-1:0]  l;
    logic [W-1:0]  r;
    logic          strobe;
    logic          locked;
`ifdef I2S_IN_ERR_EN
    logic          err;
    int            err_cnt = 0;
    localparam logic LK12 = 1'b0;
`else
    localparam logic LK12 = 1'b1;
`endif

    i2s_in #(.WIDTH(W), .SYNC(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i2s     (i2s),
        .l       (l),
        .r       (r),
        .strobe  (strobe),
`ifdef I2S_IN_ERR_EN
        .err     (err),
`endif
        .locked  (locked)
    );

    always #5 clock = ~clock;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [32:0]  sb_q[$];
    logic [32:0]  mon_e;
    int           half     = 4;
    logic         pend_d   = 1'b0;
    int           gap_chk  = 0;
    int           cyc      = 0;
    int           last_stb = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe pops one expected {locked, l, r} entry.
    always @(negedge clock) begin
        if (reset_n && strobe) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: l=%h r=%h, no pair expected", l, r);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_l", 32'(l), 32'(mon_e[31:16]));
                check("strobe_r", 32'(r), 32'(mon_e[15:0]));
                check("strobe_locked", 32'(locked), 32'(mon_e[32]));
            end
            if (gap_chk != 0 && last_stb >= 0)
                check("strobe_spacing", 32'(cyc - last_stb), 32'(gap_chk));
            last_stb = cyc;
        end
`ifdef I2S_IN_ERR_EN
        if (reset_n && err) err_cnt++;
`endif
    end

    // One I2S bit period: lr and data change with the falling ck, receiver samples on the rise.
    task automatic tx_bit(input logic lrv, input logic dv);
        @(posedge clock); #1;
        i2s = {dv, lrv, 1'b0};
        repeat (half - 1) @(posedge clock);
        @(posedge clock); #1;
        i2s[0] = 1'b1;
        repeat (half - 1) @(posedge clock);
    endtask

    // Slot bits are emitted one period late: lr leads the data by one bit.
    task automatic send_slot(input logic ch, input logic [15:0] w, input int nb,
                             input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            logic b;
            b = (i < nb) ? w[nb-1-i] : 1'b0;
            tx_bit(ch, pend_d);
            pend_d = b;
        end
    endtask

    task automatic send_frame(input int slot, input int nb, input logic [15:0] lv,
                              input logic [15:0] rv, input logic push, input logic [32:0] exp);
        if (push) sb_q.push_back(exp);
        send_slot(1'b0, lv, nb, 0, slot);
        send_slot(1'b1, rv, nb, 0, slot);
    endtask

    task automatic flush();
        tx_bit(1'b0, pend_d);
        pend_d = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 4000 && sb_q.size() != 0; k++) @(posedge clock);
        repeat (20) @(posedge clock);
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset_n  = 1'b0;
        i2s      = 3'b000;
        pend_d   = 1'b0;
        last_stb = -1;
        @(negedge clock);
        check("reset_l", 32'(l), 32'd0);
        check("reset_r", 32'(r), 32'd0);
        check("reset_strobe", 32'(strobe), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        do_reset();

        // Loopback-style 32-bit slots, then reset in the middle of a left word.
        half = 4; gap_chk = 64 * 8;
        send_frame(32, 16, 16'h1234, 16'hABCD, 1'b0, 33'd0);
        for (int f = 0; f < 3; f++)
            send_frame(32, 16, 16'h1234, 16'hABCD, 1'b1, {1'b1, 16'h1234, 16'hABCD});
        send_slot(1'b0, 16'h5A5A, 16, 0, 10);
        wait_drain("drain_loop32");
        check("hold_l", 32'(l), 32'h1234);
        check("hold_r", 32'(r), 32'hABCD);
        check("hold_locked", 32'(locked), 32'd1);
        do_reset();
        send_frame(32, 16, 16'h0F0F, 16'hF0F0, 1'b0, 33'd0);
        for (int f = 0; f < 2; f++)
            send_frame(32, 16, 16'h0F0F, 16'hF0F0, 1'b1, {1'b1, 16'h0F0F, 16'hF0F0});
        wait_drain("drain_after_reset");

        // Exact 16-bit slots, lr toggling with the last bit.
        do_reset();
        gap_chk = 32 * 8;
        send_frame(16, 16, 16'h8001, 16'h7FFE, 1'b0, 33'd0);
        for (int f = 0; f < 3; f++)
            send_frame(16, 16, 16'h8001, 16'h7FFE, 1'b1, {1'b1, 16'h8001, 16'h7FFE});
        flush();
        wait_drain("drain_slot16");

        // Short 12-bit slots are left-aligned with zero padding.
        do_reset();
`ifdef I2S_IN_ERR_EN
        err_cnt = 0;
`endif
        gap_chk = 24 * 8;
        send_frame(12, 12, 16'h0ABC, 16'h0123, 1'b0, 33'd0);
        for (int f = 0; f < 2; f++)
            send_frame(12, 12, 16'h0ABC, 16'h0123, 1'b1, {LK12, 16'hABC0, 16'h1230});
        flush();
        wait_drain("drain_slot12");
`ifdef I2S_IN_ERR_EN
        check("err_pulses", 32'(err_cnt), 32'd5);
        check("locked_after_short", 32'(locked), 32'd0);
`endif

        // Stream joined in the middle of a right slot.
        do_reset();
        gap_chk = 64 * 8;
        send_slot(1'b1, 16'hFFFF, 16, 8, 32);
        for (int f = 0; f < 2; f++)
            send_frame(32, 16, 16'h2468, 16'h1357, 1'b1, {1'b1, 16'h2468, 16'h1357});
        wait_drain("drain_midright");

        // Minimum ck ratio, 100 consecutive frames of alternating patterns.
        do_reset();
        half = 2; gap_chk = 32 * 4;
        send_frame(16, 16, 16'h5555, 16'hAAAA, 1'b0, 33'd0);
        for (int f = 0; f < 100; f++) begin
            if (f % 2 == 0)
                send_frame(16, 16, 16'hAAAA, 16'h5555, 1'b1, {1'b1, 16'hAAAA, 16'h5555});
            else
                send_frame(16, 16, 16'h5555, 16'hAAAA, 1'b1, {1'b1, 16'h5555, 16'hAAAA});
        end
        flush();
        wait_drain("drain_minratio");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
